// File: rtl/fir_fifo_drain.sv
// FIFO drain engine: issues bounded read bursts to an upstream FIFO and
// streams the returned words out through a 2-entry skid buffer with
// valid/ready handshaking. Also counts delivered samples and keeps a
// sticky overflow flag for writes into a full FIFO.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for drain_en with a non-empty FIFO
// READ  | issuing reads, at most BURST_LEN per burst
// FLUSH | no new reads; waiting for in-flight word and buffer to drain
module fir_fifo_drain #(
    parameter int DWIDTH    = 16,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              drain_en,
    input  logic              empty_flg,
    input  logic              full_flg,
    input  logic              write_en,
    input  logic [DWIDTH-1:0] rdata,
    output logic              read_en,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow_flg,
    input  logic              clr_ovf,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [8:0] BURST_LIM = 9'(BURST_LEN);

    logic [1:0]        state_q, state_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        occ_q, occ_d;
    logic [DWIDTH-1:0] buf0_q, buf0_d;
    logic [DWIDTH-1:0] buf1_q, buf1_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic              ovf_q, ovf_d;

    logic              xfer;
    logic [2:0]        pending;
    logic              rd_ok;
    logic [1:0]        base;

    // Handshake and read-permission terms; a read is only allowed when the
    // word it returns is guaranteed a free buffer slot.
    always_comb begin
        xfer      = (occ_q != 2'd0) && out_ready;
        pending   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, xfer};
        rd_ok     = !empty_flg && drain_en && (pending < 3'd2);
        read_en   = (state_q == S_READ) && rd_ok;
        out_valid = (occ_q != 2'd0);
        out_data  = buf0_q;
        busy      = (state_q != S_IDLE);
    end

    // Burst sequencing: next state and burst counter.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (drain_en && !empty_flg) begin
                    state_d     = S_READ;
                    burst_cnt_d = 8'd0;
                end
            end
            S_READ: begin
                if (read_en) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    if (({1'b0, burst_cnt_q} + 9'd1) == BURST_LIM) begin
                        state_d = S_FLUSH;
                    end
                end else if (empty_flg || !drain_en) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!inflight_q && (occ_q == 2'd0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Skid buffer: pop the head on transfer, then append the returning word.
    always_comb begin
        inflight_d = read_en;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        base       = occ_q - {1'b0, xfer};
        if (xfer) begin
            buf0_d = buf1_q;
        end
        if (inflight_q) begin
            if (base == 2'd0) begin
                buf0_d = rdata;
            end else begin
                buf1_d = rdata;
            end
        end
        occ_d = base + {1'b0, inflight_q};
    end

    // Delivered-sample counter and sticky overflow (a new set beats clear).
    always_comb begin
        sample_cnt_d = sample_cnt_q + {{(CNT_W-1){1'b0}}, xfer};
        if (write_en && full_flg) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        overflow_flg = ovf_q;
        sample_cnt   = sample_cnt_q;
    end

    // State registers; reset discards any buffered or in-flight words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            burst_cnt_q  <= 8'd0;
            inflight_q   <= 1'b0;
            occ_q        <= 2'd0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            sample_cnt_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            inflight_q   <= inflight_d;
            occ_q        <= occ_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            sample_cnt_q <= sample_cnt_d;
            ovf_q        <= ovf_d;
        end
    end

endmodule
